sample_feeder: RTL and testbench
================================

# sample_feeder

Upstream stage of the audio serializer. Buffers 16-bit PCM samples from the sample producer in a small FIFO and paces them into the serializer. For each word it holds data stable, drives the serializer's enable, and advances on the serializer's done pulse. It also generates the sample-rate strobe the producer uses, and reports FIFO underruns.

## Interface
- WORD_LENGTH, 16: sample width; must match the serializer.
- FIFO_DEPTH, 4: sample buffer entries, power of two, ≥2.
- SYSTEM_FREQUENCY, 100000000: clock_i frequency in Hz.
- SAMPLING_FREQUENCY, 1000000: sample strobe rate in Hz; TICK_DIV = SYSTEM_FREQUENCY/SAMPLING_FREQUENCY, must be ≥ WORD_LENGTH+2.

Ports:
- clock_i  in  1  system clock; single clock domain.
- reset_n_i  in  1  reset, synchronous, active-low.
- enable_i  in  1  run request.
- sample_tick_o  out  1  one-cycle strobe every TICK_DIV cycles while enabled.
- in_data_i  in  WORD_LENGTH  sample from producer.
- in_valid_i  in  1  in_data_i valid.
- in_ready_o  out  1  FIFO not full; registered.
- ser_data_o  out  WORD_LENGTH  word to serializer; registered, stable while ser_enable_o=1.
- ser_enable_o  out  1  serializer enable.
- ser_done_i  in  1  serializer word-complete pulse.
- underrun_o  out  1  one-cycle pulse, word loaded from empty FIFO.
- underrun_count_o  out  16  saturating underrun count.
- level_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

## Operation
- FSM states: IDLE, LOAD, SHIFT.
- IDLE: ser_enable_o=0. Moves to LOAD on enable_i=1.
- LOAD (always exactly 1 cycle):
  - FIFO non-empty: pop the head into ser_data_o.
  - FIFO empty: hold the previous ser_data_o, pulse underrun_o, increment underrun_count_o (saturates at 16'hFFFF).
  - Always moves to SHIFT.
- SHIFT: ser_enable_o = ~ser_done_i. This is the only combinational input-to-output path; it prevents the serializer from restarting on stale data.
  - On ser_done_i=1: go to LOAD if enable_i=1, else to IDLE.
  - enable_i falling during SHIFT does not abort the word. The current word completes first.
- FIFO push: in_valid_i & in_ready_o. Pop happens only in LOAD.
- Simultaneous push/pop: both occur; level unchanged.
- Push into an empty FIFO in the same cycle as LOAD: no bypass. The pop sees empty, so an underrun is recorded.
- in_ready_o depends only on registered occupancy, never on the pop in the same cycle.
- Tick counter: counts 0..TICK_DIV-1 while enable_i=1 and pulses sample_tick_o at TICK_DIV-1. Held at 0 while enable_i=0.

## Timing
- Reset values (reset_n_i=0 at a clock edge):
  - state IDLE, FIFO empty, level_o=0, in_ready_o=1.
  - ser_data_o=0, ser_enable_o=0, underrun_o=0, underrun_count_o=0.
  - tick counter 0, sample_tick_o=0.
- Reset mid-word: everything returns to reset values on the next edge. Buffered samples are discarded.
- Word period with the serializer: 1 LOAD cycle + WORD_LENGTH SHIFT cycles with enable high + 1 done cycle with enable low = WORD_LENGTH+2 cycles (18 for the defaults).
- Startup latency: enable_i rises at edge N → LOAD in cycle N+1 → ser_enable_o=1 from cycle N+2.
- ser_data_o changes only on the edge leaving LOAD.
- in_ready_o updates on the edge after a push or pop.

## Structure
- Package audio_pkg holds:
  - the WORD_LENGTH default,
  - the feeder_state_t enum {IDLE, LOAD, SHIFT},
  - the tick_div(sys, samp) constant function,
  - the underrun counter width constant.
- One sub-module, sample_fifo: synchronous FIFO with registered full/empty/level and the same reset.
- FSM, tick counter and underrun counter live in sample_feeder.
- Elaboration assertions: TICK_DIV ≥ WORD_LENGTH+2; FIFO_DEPTH is a power of two.

## Test plan
- Reset, then push 16'hA5C3 and raise enable_i → ser_data_o=16'hA5C3 after LOAD, and ser_enable_o high for 16 cycles, low on done, then a fresh LOAD; with the serializer attached, the bit stream is 1010010111000011 MSB first.
- Push 4 words with enable_i=0 → in_ready_o=0 and level_o=4; a 5th push is ignored; enable → words emerge in order, with one word every 18 cycles.
- Empty FIFO at LOAD → underrun_o pulses once, ser_data_o repeats the prior word, underrun_count_o increments; force 70000 underruns → count saturates at 16'hFFFF.
- Drop enable_i mid-word → the current word finishes, ser_enable_o goes low at done, FSM returns to IDLE, and the FIFO retains the remaining entries.
- Assert reset_n_i=0 mid-SHIFT with 3 words buffered → next cycle: all outputs at reset values, level_o=0.
- Defaults with enable_i held high → sample_tick_o pulses every 100 cycles; held at 0 while enable_i=0.

Source files
------------

// File: rtl/audio_pkg.sv
// +--------------------------------------------------------------------+
// | audio_pkg: shared types and constants for the audio feeder path     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package audio_pkg;

  localparam int DEFAULT_WORD_LENGTH = 16;
  localparam int UNDERRUN_COUNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } feeder_state_t;

  function automatic int tick_div(input longint sys, input longint samp);
    return int'(sys / samp);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// +--------------------------------------------------------------------+
// | sample_fifo: synchronous FIFO with registered full/empty/level      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module sample_fifo #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   push_data_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [LEVEL_W-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic               r_full;
  logic               r_empty;
  logic               w_push;
  logic               w_pop;
  logic [LEVEL_W-1:0] w_level_next;

  assign w_push = push_i & ~r_full;
  assign w_pop  = pop_i & ~r_empty;

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LEVEL_W'(1);
      2'b01:   w_level_next = r_level - LEVEL_W'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_next;
      r_full  <= (w_level_next == LEVEL_W'(DEPTH));
      r_empty <= (w_level_next == '0);
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign full_o  = r_full;
  assign empty_o = r_empty;
  assign level_o = r_level;

endmodule

`default_nettype wire

// File: rtl/sample_feeder.sv
// +--------------------------------------------------------------------+
// | sample_feeder: buffers PCM samples and paces them to the serializer |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module sample_feeder
  import audio_pkg::*;
#(
  parameter int WORD_LENGTH        = DEFAULT_WORD_LENGTH,
  parameter int FIFO_DEPTH         = 4,
  parameter int SYSTEM_FREQUENCY   = 100000000,
  parameter int SAMPLING_FREQUENCY = 1000000
) (
  input  logic                                clock_i,
  input  logic                                reset_n_i,
  input  logic                                enable_i,
  output logic                                sample_tick_o,
  input  logic [WORD_LENGTH-1:0]              in_data_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  output logic [WORD_LENGTH-1:0]              ser_data_o,
  output logic                                ser_enable_o,
  input  logic                                ser_done_i,
  output logic                                underrun_o,
  output logic [UNDERRUN_COUNT_W-1:0]         underrun_count_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level_o
);

  localparam int TICK_DIV = tick_div(SYSTEM_FREQUENCY, SAMPLING_FREQUENCY);
  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int LEVEL_W  = $clog2(FIFO_DEPTH + 1);

  if (TICK_DIV < WORD_LENGTH + 2) begin : g_bad_tick_div
    $error("sample_feeder: TICK_DIV too small for one word period");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sample_feeder: FIFO_DEPTH must be a power of two and at least 2");
  end

  feeder_state_t               r_state;
  logic [WORD_LENGTH-1:0]      r_ser_data;
  logic                        r_underrun;
  logic [UNDERRUN_COUNT_W-1:0] r_underrun_count;
  logic [TICK_W-1:0]           r_tick_count;
  logic                        w_fifo_pop;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [WORD_LENGTH-1:0]      w_fifo_head;
  logic [LEVEL_W-1:0]          w_fifo_level;

  assign w_fifo_pop = (r_state == LOAD) & ~w_fifo_empty;

  sample_fifo #(
    .WIDTH   (WORD_LENGTH),
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .push_i      (in_valid_i),
    .push_data_i (in_data_i),
    .pop_i       (w_fifo_pop),
    .head_o      (w_fifo_head),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .level_o     (w_fifo_level)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_state          <= IDLE;
      r_ser_data       <= '0;
      r_underrun       <= 1'b0;
      r_underrun_count <= '0;
    end else begin
      r_underrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable_i) r_state <= LOAD;
        end
        LOAD: begin
          if (!w_fifo_empty) begin
            r_ser_data <= w_fifo_head;
          end else begin
            // Empty: the serializer replays the previous word.
            r_underrun <= 1'b1;
            if (r_underrun_count != '1) begin
              r_underrun_count <= r_underrun_count + UNDERRUN_COUNT_W'(1);
            end
          end
          r_state <= SHIFT;
        end
        SHIFT: begin
          if (ser_done_i) r_state <= enable_i ? LOAD : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i || !enable_i) begin
      r_tick_count <= '0;
    end else if (r_tick_count == TICK_W'(TICK_DIV - 1)) begin
      r_tick_count <= '0;
    end else begin
      r_tick_count <= r_tick_count + TICK_W'(1);
    end
  end

  // Dropping enable on done keeps the serializer from restarting on stale data.
  assign ser_enable_o     = (r_state == SHIFT) & ~ser_done_i;
  assign ser_data_o       = r_ser_data;
  assign underrun_o       = r_underrun;
  assign underrun_count_o = r_underrun_count;
  assign in_ready_o       = ~w_fifo_full;
  assign level_o          = w_fifo_level;
  assign sample_tick_o    = (r_tick_count == TICK_W'(TICK_DIV - 1));

endmodule

`default_nettype wire

// File: tb/tb_sample_feeder.sv
// +--------------------------------------------------------------------+
// | tb_sample_feeder: directed bench with a queue-based reference model |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sample_feeder;

  localparam int WL    = 16;
  localparam int DEPTH = 4;
  localparam int TD    = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        force_done = 1'b0;
  logic        auto_done;
  logic        ser_done;
  logic        sample_tick, in_ready, ser_enable, underrun;
  logic [15:0] ser_data, underrun_count;
  logic [2:0]  level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  assign ser_done = force_done | auto_done;

  always #5 clk = ~clk;

  sample_feeder #(
    .WORD_LENGTH        (WL),
    .FIFO_DEPTH         (DEPTH),
    .SYSTEM_FREQUENCY   (100000000),
    .SAMPLING_FREQUENCY (1000000)
  ) dut (
    .clock_i          (clk),
    .reset_n_i        (reset_n),
    .enable_i         (enable),
    .sample_tick_o    (sample_tick),
    .in_data_i        (in_data),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .ser_data_o       (ser_data),
    .ser_enable_o     (ser_enable),
    .ser_done_i       (ser_done),
    .underrun_o       (underrun),
    .underrun_count_o (underrun_count),
    .level_o          (level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Serializer stand-in: shifts WL bits MSB first, then a one-cycle done.
  int          s_cnt;
  int          s_words;
  logic [15:0] s_shreg, s_captured;
  always @(posedge clk) begin
    if (!reset_n) begin
      s_cnt <= 0; auto_done <= 1'b0; s_words <= 0; s_shreg <= '0; s_captured <= '0;
    end else if (auto_done) begin
      auto_done <= 1'b0; s_cnt <= 0; s_captured <= s_shreg; s_words <= s_words + 1;
    end else if (ser_enable) begin
      s_shreg <= {s_shreg[14:0], ser_data[15 - s_cnt]};
      s_cnt   <= s_cnt + 1;
      if (s_cnt == WL - 1) auto_done <= 1'b1;
    end
  end

  // Reference model: FIFO as a queue, word pacing as a phase variable.
  logic [15:0] m_q[$];
  int          m_phase;   // 0 idle, 1 loading, 2 shifting
  logic [15:0] m_data;
  logic        m_under;
  logic [15:0] m_count;
  int          m_tick;
  bit          m_valid = 1'b0;
  bit          m_push;
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_q.delete(); m_phase = 0; m_data = '0; m_under = 1'b0;
      m_count = '0; m_tick = 0; m_valid = 1'b1;
    end else begin
      m_push  = in_valid && (m_q.size() < DEPTH);
      m_under = 1'b0;
      case (m_phase)
        0: if (enable) m_phase = 1;
        1: begin
          if (m_q.size() > 0) m_data = m_q.pop_front();
          else begin
            m_under = 1'b1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          end
          m_phase = 2;
        end
        default: if (ser_done) m_phase = enable ? 1 : 0;
      endcase
      if (m_push) m_q.push_back(in_data);
      m_tick = enable ? (m_tick + 1) % TD : 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ser_enable", 32'(ser_enable), 32'((m_phase == 2) && !ser_done));
      check("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
      check("level", 32'(level), 32'(m_q.size()));
      check("ser_data", 32'(ser_data), 32'(m_data));
      check("underrun", 32'(underrun), 32'(m_under));
      check("underrun_count", 32'(underrun_count), 32'(m_count));
      check("sample_tick", 32'(sample_tick), 32'(m_tick == TD - 1));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    in_valid = 1'b1; in_data = d;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_rise(input string name, output int at);
    bit prev;
    bit ok;
    prev = ser_enable; ok = 1'b0; at = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step(1);
      if (ser_enable && !prev) begin ok = 1'b1; at = cyc; end
      prev = ser_enable;
    end
    if (!ok) check({"timeout_", name}, 32'd0, 32'd1);
  endtask

  initial begin
    int          t, t_prev, start;
    int          ticks[3];
    int          nt;
    logic [15:0] words[5];
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

    step(3);
    check("reset_level", 32'(level), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_ser_data", 32'(ser_data), 32'd0);
    check("reset_count", 32'(underrun_count), 32'd0);
    reset_n = 1'b1;
    step(1);

    // Single word and its bit stream
    push(16'hA5C3);
    enable = 1'b1;
    wait_rise("first_word", t);
    check("first_word_data", 32'(ser_data), 32'h0000A5C3);
    start = s_words;
    for (int i = 0; i < 40 && s_words == start; i++) step(1);
    check("bitstream", 32'(s_captured), 32'b1010010111000011);
    enable = 1'b0;
    step(40);

    // Fill to full, fifth push ignored, words in order at 18-cycle spacing
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = words[i];
      step(1);
    end
    in_valid = 1'b0;
    check("full_level", 32'(level), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    enable = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_rise("burst", t);
      check("burst_word", 32'(ser_data), 32'(words[i]));
      if (i > 0) check("word_period", 32'(t - t_prev), 32'd18);
      t_prev = t;
    end
    enable = 1'b0;
    step(40);

    // Enable dropped mid-word: word finishes, rest stays buffered
    push(16'h6666); push(16'h7777); push(16'h8888);
    enable = 1'b1;
    wait_rise("drop", t);
    step(5);
    enable = 1'b0;
    step(40);
    check("drop_level", 32'(level), 32'd2);
    check("drop_data", 32'(ser_data), 32'h00006666);
    check("drop_idle_enable", 32'(ser_enable), 32'd0);

    // Reset in the middle of a word with three buffered samples
    push(16'h9999);
    enable = 1'b1;
    wait_rise("pre_reset", t);
    push(16'hAAAA);
    step(3);
    check("pre_reset_level", 32'(level), 32'd3);
    reset_n = 1'b0;
    step(1);
    check("midreset_level", 32'(level), 32'd0);
    check("midreset_enable", 32'(ser_enable), 32'd0);
    check("midreset_data", 32'(ser_data), 32'd0);
    check("midreset_ready", 32'(in_ready), 32'd1);
    enable = 1'b0;
    reset_n = 1'b1;
    step(2);

    // Sample strobe period, then silence while disabled
    enable = 1'b1;
    nt = 0;
    for (int i = 0; i < 350 && nt < 3; i++) begin
      step(1);
      if (sample_tick) begin ticks[nt] = cyc; nt++; end
    end
    if (nt < 3) check("timeout_tick", 32'd0, 32'd1);
    else begin
      check("tick_period_a", 32'(ticks[1] - ticks[0]), 32'd100);
      check("tick_period_b", 32'(ticks[2] - ticks[1]), 32'd100);
    end
    enable = 1'b0;
    nt = 0;
    for (int i = 0; i < 150; i++) begin
      step(1);
      if (sample_tick) nt++;
    end
    check("tick_disabled", 32'(nt), 32'd0);
    step(40);

    // Push in the LOAD cycle of an empty FIFO: no bypass
    start = int'(underrun_count);
    enable = 1'b1;
    step(1);
    push(16'hBBBB);
    check("nobypass_underrun", 32'(underrun), 32'd1);
    check("nobypass_count", 32'(underrun_count), 32'(start + 1));
    check("nobypass_level", 32'(level), 32'd1);
    wait_rise("nobypass_next", t);
    check("nobypass_data", 32'(ser_data), 32'h0000BBBB);
    enable = 1'b0;
    step(40);

    // Counter saturation, preloaded just below the ceiling
    force dut.r_underrun_count = 16'hFFFD;
    m_count = 16'hFFFD;
    step(1);
    release dut.r_underrun_count;
    force_done = 1'b1;
    enable = 1'b1;
    step(20);
    enable = 1'b0;
    step(5);
    force_done = 1'b0;
    step(2);
    check("saturated_count", 32'(underrun_count), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
